// File: rtl/spart_pkg.sv
// spart_pkg: register map, STATUS bit positions, FSM state codes and oversampling ratio for spart_fifo_uart.
package spart_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;
  localparam int ST_RDA     = 0;
  localparam int ST_TBR     = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_OVR     = 4;
  localparam int ST_FERR    = 5;
  localparam int ST_PERR    = 6;
  localparam int OVERSAMPLE = 16;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;
endpackage

// File: rtl/spart_fifo_uart_fifo.sv
// spart_sync_fifo: synchronous FIFO; push+pop in one cycle are both taken and leave the count unchanged.
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop  = pop & (~empty | push);
  assign w_push = push & (~full | pop);
  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop) r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/spart_fifo_uart.sv
// spart_fifo_uart: CPU-bus UART with TX/RX FIFOs, 16-bit divisor, 16x oversampled RX and sticky error flags.
// Define SPART_PARITY_EN to append an even-parity bit to every frame and report mismatches in STATUS[6].
module spart_fifo_uart
  import spart_pkg::*;
#(
  parameter int          CHAR_BITS = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
`ifdef SPART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam logic [3:0] T_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] T_END  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] B_LAST = 3'(CHAR_BITS - 1);
  logic w_rd, w_wr, w_tick;
  logic [15:0] r_div, r_baud;
  logic [7:0] w_status, w_rdata;
  logic r_ovr, r_ferr, r_perr;
  logic [2:0] w_clr;
  logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_load, w_tx_end;
  logic [CHAR_BITS-1:0] w_tx_dout, w_rx_dout;
  logic [TXCW-1:0] w_tx_cnt;
  logic [RXCW-1:0] w_rx_cnt;
  state_t r_tx_st, r_rx_st;
  logic [3:0] r_tx_tc, r_rx_tc;
  logic [2:0] r_tx_bc, r_rx_bc;
  logic [CHAR_BITS-1:0] r_tx_sh, r_rx_sh;
  logic r_tx_par, r_rx_par;
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  logic w_rx_smp, w_rx_end, w_rx_done, w_rx_good, w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  assign w_rd   = iocs & iorw;
  assign w_wr   = iocs & ~iorw;
  assign w_tick = r_baud == 16'd0;
  // Divisor changes are picked up only when the counter next reloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= DIV_RESET;
      r_baud <= DIV_RESET;
    end else begin
      r_baud <= w_tick ? r_div : r_baud - 16'd1;
      if (w_wr & (ioaddr == ADDR_DIV_LO)) r_div[7:0] <= databus;
      if (w_wr & (ioaddr == ADDR_DIV_HI)) r_div[15:8] <= databus;
    end
  end
  assign w_tx_push = w_wr & (ioaddr == ADDR_DATA);
  assign w_tx_end  = w_tick & (r_tx_tc == T_END);
  assign w_tx_load = w_tick & ~w_tx_empty & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_end));
  assign w_tx_pop  = w_tx_load;
  spart_sync_fifo #(.WIDTH(CHAR_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (databus[CHAR_BITS-1:0]),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_cnt)
  );
  // A frame ending with data waiting goes straight into the next start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st  <= S_IDLE;
      r_tx_tc  <= 4'd0;
      r_tx_bc  <= 3'd0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
    end else begin
      if (w_tick) r_tx_tc <= (r_tx_st == S_IDLE) ? 4'd0 : r_tx_tc + 4'd1;
      if (w_tx_load) begin
        r_tx_st  <= S_START;
        r_tx_sh  <= w_tx_dout;
        r_tx_par <= ^w_tx_dout;
      end else if (w_tx_end) begin
        case (r_tx_st)
          S_START: begin
            r_tx_st <= S_DATA;
            r_tx_bc <= 3'd0;
          end
          S_DATA: begin
            r_tx_sh <= r_tx_sh >> 1;
            r_tx_bc <= r_tx_bc + 3'd1;
            if (r_tx_bc == B_LAST) r_tx_st <= PAR_EN ? S_PARITY : S_STOP;
          end
          S_PARITY: r_tx_st <= S_STOP;
          default:  r_tx_st <= S_IDLE;
        endcase
      end
    end
  end
  assign txd = (r_tx_st == S_START) ? 1'b0 : (r_tx_st == S_DATA) ? r_tx_sh[0] :
               (r_tx_st == S_PARITY) ? r_tx_par : 1'b1;
  assign w_rx_smp  = w_tick & (r_rx_tc == T_MID);
  assign w_rx_end  = w_tick & (r_rx_tc == T_END);
  assign w_rx_done = (r_rx_st == S_STOP) & w_rx_smp;
  assign w_rx_good = w_rx_done & r_rx_s2;
  assign w_rx_pop  = w_rd & (ioaddr == ADDR_DATA) & ~w_rx_empty;
  assign w_rx_push = w_rx_good & (~w_rx_full | w_rx_pop);
  spart_sync_fifo #(.WIDTH(CHAR_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (r_rx_sh),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_cnt)
  );
  // The receiver leaves STOP at mid-bit so it is already idle for a back-to-back start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= S_IDLE;
      r_rx_tc   <= 4'd0;
      r_rx_bc   <= 3'd0;
      r_rx_sh   <= '0;
      r_rx_par  <= 1'b0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (w_tick) r_rx_tc <= r_rx_tc + 4'd1;
      case (r_rx_st)
        S_IDLE: if (r_rx_prev & ~r_rx_s2) begin
          r_rx_st <= S_START;
          r_rx_tc <= 4'd0;
        end
        S_START: if (w_rx_smp & r_rx_s2) r_rx_st <= S_IDLE;
          else if (w_rx_end) begin
            r_rx_st <= S_DATA;
            r_rx_bc <= 3'd0;
          end
        S_DATA: begin
          if (w_rx_smp) r_rx_sh <= {r_rx_s2, r_rx_sh[CHAR_BITS-1:1]};
          if (w_rx_end) begin
            r_rx_bc <= r_rx_bc + 3'd1;
            if (r_rx_bc == B_LAST) r_rx_st <= PAR_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_rx_smp) r_rx_par <= r_rx_s2;
          if (w_rx_end) r_rx_st <= S_STOP;
        end
        default: if (w_rx_smp) r_rx_st <= S_IDLE;
      endcase
    end
  end
  assign w_clr = (w_wr & (ioaddr == ADDR_STATUS)) ? databus[6:4] : 3'b000;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ovr  <= (w_tx_push & w_tx_full & ~w_tx_pop) | (w_rx_good & w_rx_full & ~w_rx_pop) | (r_ovr & ~w_clr[0]);
      r_ferr <= (w_rx_done & ~r_rx_s2) | (r_ferr & ~w_clr[1]);
      r_perr <= (PAR_EN & w_rx_good & (r_rx_par != ^r_rx_sh)) | (r_perr & ~w_clr[2]);
    end
  end
  always_comb begin
    w_status = 8'd0;
    w_status[ST_RDA]     = ~w_rx_empty;
    w_status[ST_TBR]     = ~w_tx_full;
    w_status[ST_TX_IDLE] = (w_tx_cnt == '0) & (r_tx_st == S_IDLE);
    w_status[ST_RX_FULL] = w_rx_cnt == RXCW'(RX_DEPTH);
    w_status[ST_OVR]     = r_ovr;
    w_status[ST_FERR]    = r_ferr;
    w_status[ST_PERR]    = r_perr;
  end
  assign w_rdata = (ioaddr == ADDR_DATA) ? (w_rx_empty ? 8'd0 : 8'(w_rx_dout)) :
                   (ioaddr == ADDR_STATUS) ? w_status :
                   (ioaddr == ADDR_DIV_LO) ? r_div[7:0] : r_div[15:8];
  assign databus = w_rd ? w_rdata : 8'bz;
  assign rda = ~w_rx_empty;
  assign tbr = ~w_tx_full;
endmodule
